bcd_serial_adder_ctrl: RTL
==========================

# bcd_serial_adder_ctrl

Sequencing controller for a multi-digit packed-BCD addition that reuses a single one-digit BCD add stage, one decimal digit per clock, least-significant digit first. Operands are latched on a start handshake; the decimal carry is kept in a register between digits. A registered result and a one-cycle done pulse are produced. The block sits between a requester (keypad/accumulator logic) and the one-digit BCD adder datapath.

## Interface
- DIGITS, 4: number of BCD digits per operand (≥1); operand width is 4*DIGITS.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  4*DIGITS  packed-BCD operand, digit 0 in bits [3:0].
- B  input  4*DIGITS  packed-BCD operand.
- Cin  input  1  initial decimal carry into digit 0.
- Sum  output  4*DIGITS  registered packed-BCD result.
- Cout  output  1  registered decimal carry out of the top digit.
- busy  output  1  high while the FSM is in ADD.
- done  output  1  one-cycle pulse when Sum/Cout become valid.
- Err  output  1  operand-digit error flag (only with BCD_INPUT_CHECK_EN; otherwise tied 0).

## Operation
- FSM states: IDLE, ADD.
- IDLE: start=1 → latch A, B into shift registers, load carry=Cin, clear Sum, clear digit index, go to ADD. start=0 → stay.
- ADD, per cycle: a = A_sh[3:0], b = B_sh[3:0]; s = a + b + carry (5 bits, 0..19 for valid BCD).
- If s > 9: digit = (s + 6)[3:0], carry ← 1; else digit = s[3:0], carry ← 0.
- digit is shifted into Sum from the top (after DIGITS shifts, digit 0 sits in [3:0]); A_sh/B_sh shift right by 4; index increments.
- After digit DIGITS-1 is written: Cout ← carry out of that digit, done ← 1, go to IDLE.
- Non-BCD nibbles (>9) without the check: the same arithmetic is applied; the result is undefined as BCD but deterministic (rule above, mod 16).
- start while in ADD is ignored (no queuing); A, B, Cin changes during ADD have no effect.
- Sum, Cout hold their values in IDLE until the next accepted start.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, Sum=0, Cout=0, busy=0, done=0, Err=0, internal shift registers/carry/index=0. An in-flight add is abandoned; no done follows.
- start sampled at edge E0 → busy=1 after E0; digits computed at edges E1..E_DIGITS.
- done=1 for exactly the cycle after E_DIGITS; busy=0 in that same cycle. Latency start→done = DIGITS+1 edges after start is presented (DIGITS cycles of busy).
- Back-to-back: start=1 while done=1 (FSM in IDLE) is accepted; throughput is one add per DIGITS+1 cycles.
- Sum is partial (not valid) while busy=1; valid only from the done cycle onward.

## Configuration
- BCD_INPUT_CHECK_EN defined: at the accepting start edge, Err ← 1 if any nibble of A or B > 9, else Err ← 0; Err is held until the next accepted start. The add still runs and done still pulses.
- Not defined: no checking logic; Err is constant 0.

## Test plan
- DIGITS=4, A=0x0004, B=0x0005, Cin=0, start → done after 5 cycles, Sum=0x0009, Cout=0, busy high exactly 4 cycles.
- A=0x0007, B=0x0005, Cin=0 → Sum=0x0012, Cout=0; A=0x0999, B=0x0001, Cin=1 → Sum=0x1001, Cout=0.
- A=0x9999, B=0x0001, Cin=0 → Sum=0x0000, Cout=1; A=0x9999, B=0x9999, Cin=1 → Sum=0x9999, Cout=1.
- start held high across an add, with A/B changed mid-operation → only one done per accepted start; result uses latched operands; next add accepted in the done cycle.
- rst_n pulsed low during the 2nd ADD cycle → all outputs 0 immediately, no done; a new start afterwards completes normally.
- With BCD_INPUT_CHECK_EN: A=0x00A0, B=0x0001 → Err=1 at done; following valid add A=0x0001, B=0x0001 → Err=0, Sum=0x0002.

Source files
------------

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder controller: one decimal digit per clock, LSD first.
// Optional operand-digit check is enabled by defining BCD_INPUT_CHECK_EN.
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                Cin,
  output logic [4*DIGITS-1:0] Sum,
  output logic                Cout,
  output logic                busy,
  output logic                done,
  output logic                Err
);

  localparam int W    = 4 * DIGITS;
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic {IDLE, ADD} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            done_q, done_d;

  logic [4:0]      dig_raw;
  logic [4:0]      dig_adj;
  logic [3:0]      digit;
  logic            dig_carry;
  logic [W-1:0]    a_shr, b_shr, sum_ins;

  // One-digit BCD add stage; nibbles above 9 follow the same rule, mod 16.
  always_comb begin
    dig_raw   = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0000, carry_q};
    dig_adj   = dig_raw + 5'd6;
    digit     = dig_raw[3:0];
    dig_carry = 1'b0;
    if (dig_raw > 5'd9) begin
      digit     = dig_adj[3:0];
      dig_carry = 1'b1;
    end
  end

  generate
    if (DIGITS == 1) begin : g_one_digit
      assign a_shr   = '0;
      assign b_shr   = '0;
      assign sum_ins = digit;
    end else begin : g_multi_digit
      assign a_shr   = {4'b0000, a_sh_q[W-1:4]};
      assign b_shr   = {4'b0000, b_sh_q[W-1:4]};
      assign sum_ins = {digit, sum_q[W-1:4]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_sh_d  = a_shr;
        b_sh_d  = b_shr;
        sum_d   = sum_ins;
        carry_d = dig_carry;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = dig_carry;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  // Flag is judged on the operands as presented at the accepting edge.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (A[4*i +: 4] > 4'd9 || B[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
    err_d = err_q;
    if (state_q == IDLE && start) err_d = bad_digit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign busy = (state_q == ADD);
  assign done = done_q;

endmodule
